// File: rtl/keypad_entry.sv
// keypad_entry: assembles DIGITS 2-bit key digits into a passcode word with valid/error strobes.
// Optional feature macro: KEYPAD_TIMEOUT_EN compiles in the COLLECT inactivity timer.
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous reset, active-high despite the name
//   key_valid      strobe, key_digit carries a new digit
//   key_digit      digit value 0..3
//   key_clear      strobe, discard the entry in progress
//   key_enter      strobe, submit the entry
//   passcode       assembled word, first digit in the top bits
//   passcode_valid one-cycle pulse, passcode holds a complete entry
//   entry_busy     high while collecting
//   digit_count    digits accepted so far
//   entry_error    one-cycle pulse, entry rejected (short, overflow or timeout)
module keypad_entry #(
    parameter int DIGITS         = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_valid,
    input  logic [1:0]            key_digit,
    input  logic                  key_clear,
    input  logic                  key_enter,
    output logic [2*DIGITS-1:0]   passcode,
    output logic                  passcode_valid,
    output logic                  entry_busy,
    output logic [3:0]            digit_count,
    output logic                  entry_error
);
    localparam logic IDLE    = 1'b0;
    localparam logic COLLECT = 1'b1;
    localparam int   W       = 2 * DIGITS;

    if (DIGITS < 2 || DIGITS > 15) begin : g_bad_digits
        $error("keypad_entry: DIGITS out of range");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("keypad_entry: TIMEOUT_CYCLES out of range");
    end

    logic         state_q, state_d;
    logic [W-1:0] passcode_q, passcode_d;
    logic [3:0]   count_q, count_d;
    logic         ovf_q, ovf_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;
`ifdef KEYPAD_TIMEOUT_EN
    logic [15:0]  timer_q, timer_d;
`endif

    always_comb begin
        state_d    = state_q;
        passcode_d = passcode_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
        timer_d    = timer_q;
`endif
        if (state_q == IDLE) begin
            // first digit starts a fresh word; enter and clear are ignored here
            if (key_valid) begin
                passcode_d = {{(W-2){1'b0}}, key_digit};
                count_d    = 4'd1;
                ovf_d      = 1'b0;
                state_d    = COLLECT;
`ifdef KEYPAD_TIMEOUT_EN
                timer_d    = '0;
`endif
            end
        end else if (key_clear) begin
            passcode_d = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
            state_d    = IDLE;
        end else if (key_enter) begin
            valid_d    = count_q == 4'(DIGITS) && !ovf_q;
            err_d      = !valid_d;
            passcode_d = valid_d ? passcode_q : '0;
            count_d    = '0;
            ovf_d      = 1'b0;
            state_d    = IDLE;
        end else if (key_valid) begin
            // a digit beyond DIGITS is dropped but poisons the entry
            passcode_d = count_q < 4'(DIGITS) ? {passcode_q[W-3:0], key_digit} : passcode_q;
            count_d    = count_q < 4'(DIGITS) ? count_q + 4'd1 : count_q;
            ovf_d      = ovf_q || count_q == 4'(DIGITS);
`ifdef KEYPAD_TIMEOUT_EN
            timer_d    = '0;
`endif
        end
`ifdef KEYPAD_TIMEOUT_EN
        else if (timer_q == 16'(TIMEOUT_CYCLES - 1)) begin
            // expiry behaves exactly like a short enter
            err_d      = 1'b1;
            passcode_d = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
            state_d    = IDLE;
        end else begin
            timer_d    = timer_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= IDLE;
            passcode_q <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            passcode_q <= passcode_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
`ifdef KEYPAD_TIMEOUT_EN
            timer_q    <= timer_d;
`endif
        end
    end

    assign passcode       = passcode_q;
    assign passcode_valid = valid_q;
    assign entry_busy     = state_q;
    assign digit_count    = count_q;
    assign entry_error    = err_q;
endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed self-checking bench for keypad_entry.
module tb_keypad_entry;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        key_valid = 1'b0;
    logic [1:0]  key_digit = 2'd0;
    logic        key_clear = 1'b0;
    logic        key_enter = 1'b0;
    logic [15:0] passcode;
    logic        passcode_valid;
    logic        entry_busy;
    logic [3:0]  digit_count;
    logic        entry_error;
    int          checks = 0;
    int          errors = 0;

    keypad_entry #(.DIGITS(8), .TIMEOUT_CYCLES(10)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_valid(key_valid),
        .key_digit(key_digit),
        .key_clear(key_clear),
        .key_enter(key_enter),
        .passcode(passcode),
        .passcode_valid(passcode_valid),
        .entry_busy(entry_busy),
        .digit_count(digit_count),
        .entry_error(entry_error)
    );

    always #5 clk = ~clk;

    task automatic press(input logic v, input logic [1:0] d, input logic c, input logic e);
        key_valid = v;
        key_digit = d;
        key_clear = c;
        key_enter = e;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_clear = 1'b0;
        key_enter = 1'b0;
    endtask

    task automatic digits(input int n, input logic [1:0] d);
        for (int i = 0; i < n; i++) press(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        #2;
        checks++; if (passcode !== 16'h0000) begin errors++; $display("FAIL reset_passcode got %h want 0000", passcode); end
        checks++; if ({passcode_valid, entry_busy, entry_error} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {passcode_valid, entry_busy, entry_error}); end
        checks++; if (digit_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", digit_count); end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full;
        digits(8, 2'd3);
        checks++; if (digit_count !== 4'd8 || entry_busy !== 1'b1) begin errors++; $display("FAIL full_collect count %0d busy %b want 8 1", digit_count, entry_busy); end
        press(1'b0, 2'd0, 1'b0, 1'b1);
        checks++; if (passcode_valid !== 1'b1 || entry_error !== 1'b0) begin errors++; $display("FAIL full_valid got v%b e%b want v1 e0", passcode_valid, entry_error); end
        checks++; if (passcode !== 16'hFFFF) begin errors++; $display("FAIL full_passcode got %h want ffff", passcode); end
        checks++; if (digit_count !== 4'd0 || entry_busy !== 1'b0) begin errors++; $display("FAIL full_after count %0d busy %b want 0 0", digit_count, entry_busy); end
        idle(1);
        checks++; if (passcode_valid !== 1'b0 || passcode !== 16'hFFFF) begin errors++; $display("FAIL full_hold got v%b %h want v0 ffff", passcode_valid, passcode); end
    endtask

    task automatic test_order;
        press(1'b1, 2'd0, 1'b0, 1'b0);
        checks++; if (passcode !== 16'h0000 || digit_count !== 4'd1) begin errors++; $display("FAIL order_first got %h cnt %0d want 0000 1", passcode, digit_count); end
        press(1'b1, 2'd1, 1'b0, 1'b0);
        press(1'b1, 2'd2, 1'b0, 1'b0);
        checks++; if (passcode !== 16'h0006) begin errors++; $display("FAIL order_partial got %h want 0006", passcode); end
        press(1'b1, 2'd3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) press(1'b1, 2'(i), 1'b0, 1'b0);
        press(1'b0, 2'd0, 1'b0, 1'b1);
        checks++; if (passcode !== 16'h1B1B || passcode_valid !== 1'b1) begin errors++; $display("FAIL order_passcode got %h v%b want 1b1b v1", passcode, passcode_valid); end
    endtask

    task automatic test_short;
        digits(5, 2'd1);
        press(1'b0, 2'd0, 1'b0, 1'b1);
        checks++; if (entry_error !== 1'b1 || passcode_valid !== 1'b0) begin errors++; $display("FAIL short_pulse got e%b v%b want e1 v0", entry_error, passcode_valid); end
        checks++; if (passcode !== 16'h0000 || entry_busy !== 1'b0) begin errors++; $display("FAIL short_clear got %h busy %b want 0000 0", passcode, entry_busy); end
        idle(1);
        checks++; if (entry_error !== 1'b0) begin errors++; $display("FAIL short_width got %b want 0", entry_error); end
    endtask

    task automatic test_overflow;
        digits(9, 2'd2);
        checks++; if (digit_count !== 4'd8 || passcode !== 16'hAAAA) begin errors++; $display("FAIL ovf_hold cnt %0d %h want 8 aaaa", digit_count, passcode); end
        press(1'b0, 2'd0, 1'b0, 1'b1);
        checks++; if (entry_error !== 1'b1 || passcode_valid !== 1'b0) begin errors++; $display("FAIL ovf_pulse got e%b v%b want e1 v0", entry_error, passcode_valid); end
    endtask

    task automatic test_clear;
        digits(4, 2'd1);
        press(1'b0, 2'd0, 1'b1, 1'b0);
        checks++; if ({entry_error, entry_busy, digit_count, passcode} !== 22'd0) begin errors++; $display("FAIL clear_state e%b b%b cnt %0d %h want all 0", entry_error, entry_busy, digit_count, passcode); end
        digits(8, 2'd2);
        press(1'b0, 2'd0, 1'b0, 1'b1);
        checks++; if (passcode !== 16'hAAAA || passcode_valid !== 1'b1) begin errors++; $display("FAIL clear_reentry got %h v%b want aaaa v1", passcode, passcode_valid); end
    endtask

    task automatic test_idle_ignore;
        press(1'b0, 2'd0, 1'b1, 1'b1);
        checks++; if ({passcode_valid, entry_error, entry_busy} !== 3'b000 || passcode !== 16'hAAAA) begin errors++; $display("FAIL idle_ignore flags %b %h want 000 aaaa", {passcode_valid, entry_error, entry_busy}, passcode); end
    endtask

    task automatic test_priority;
        digits(8, 2'd3);
        press(1'b1, 2'd0, 1'b1, 1'b1);
        checks++; if ({passcode_valid, entry_error, entry_busy} !== 3'b000 || digit_count !== 4'd0) begin errors++; $display("FAIL prio_clear flags %b cnt %0d want 000 0", {passcode_valid, entry_error, entry_busy}, digit_count); end
        digits(8, 2'd1);
        press(1'b1, 2'd3, 1'b0, 1'b1);
        checks++; if (passcode_valid !== 1'b1 || passcode !== 16'h5555) begin errors++; $display("FAIL prio_enter got v%b %h want v1 5555", passcode_valid, passcode); end
    endtask

    task automatic test_reset_mid;
        digits(6, 2'd3);
        #2;
        rst_n = 1'b1;
        #1;
        checks++; if ({passcode_valid, entry_error, entry_busy, digit_count, passcode} !== 23'd0) begin errors++; $display("FAIL reset_mid v%b e%b b%b cnt %0d %h want all 0", passcode_valid, entry_error, entry_busy, digit_count, passcode); end
        @(negedge clk);
        rst_n = 1'b0;
        idle(1);
    endtask

    task automatic test_timeout;
        digits(3, 2'd2);
        idle(9);
`ifdef KEYPAD_TIMEOUT_EN
        checks++; if (entry_busy !== 1'b1 || entry_error !== 1'b0) begin errors++; $display("FAIL tmo_early busy %b e%b want 1 0", entry_busy, entry_error); end
        idle(1);
        checks++; if (entry_error !== 1'b1 || entry_busy !== 1'b0 || passcode !== 16'h0000) begin errors++; $display("FAIL tmo_expire e%b busy %b %h want 1 0 0000", entry_error, entry_busy, passcode); end
`else
        idle(1);
        checks++; if (digit_count !== 4'd3 || entry_busy !== 1'b1 || entry_error !== 1'b0) begin errors++; $display("FAIL tmo_none cnt %0d busy %b e%b want 3 1 0", digit_count, entry_busy, entry_error); end
        press(1'b0, 2'd0, 1'b1, 1'b0);
`endif
    endtask

    initial begin
        test_reset;
        test_full;
        test_order;
        test_short;
        test_overflow;
        test_clear;
        test_idle_ignore;
        test_priority;
        test_reset_mid;
        test_timeout;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_entry.md
# keypad_entry

Collects 2-bit key digits from the keypad front end, assembles eight of them into the 16-bit passcode word, and presents that word with a one-cycle valid strobe to the door-lock comparator stage directly downstream. It also handles the clear key, short or over-long entries, and an optional inactivity timeout, so the comparator only sees complete, registered passcode words.

## Interface
Parameters:
- `DIGITS`, 8: digits per passcode; `passcode` width is 2*DIGITS (16 at default).
- `TIMEOUT_CYCLES`, 1000: idle cycles allowed between keys in COLLECT; legal range 2 to 65535.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-high (asserted = 1).
- `key_valid`  in  1  one-cycle strobe: `key_digit` holds a new digit.
- `key_digit`  in  2  digit value 0..3.
- `key_clear`  in  1  one-cycle strobe: discard the entry in progress.
- `key_enter`  in  1  one-cycle strobe: submit the entry.
- `passcode`  out  16  assembled word; stable from the `passcode_valid` pulse until the next digit is accepted.
- `passcode_valid`  out  1  one-cycle pulse: `passcode` is a complete entry.
- `entry_busy`  out  1  high while in COLLECT.
- `digit_count`  out  4  digits accepted so far, 0..DIGITS.
- `entry_error`  out  1  one-cycle pulse: entry rejected (short, overflow, or timeout).

## Operation
- Reset values: `passcode`=16'h0000, `passcode_valid`=0, `entry_busy`=0, `digit_count`=0, `entry_error`=0; state IDLE; overflow flag 0; timer 0.
- States: IDLE, COLLECT.
- IDLE: on `key_valid`, shift the digit in, set count=1, go to COLLECT. `key_enter` and `key_clear` are ignored.
- Shift rule: passcode <= {passcode[13:0], key_digit}. After 8 digits, the first digit sits in [15:14] and the last in [1:0].
- Entering COLLECT from IDLE clears the held word before the shift, so the upper bits are 0.
- COLLECT, `key_valid` with count<DIGITS: shift, count+1, reload the timer.
- COLLECT, `key_valid` with count==DIGITS: digit discarded, overflow flag set, timer reloaded.
- COLLECT, `key_enter`:
  - count==DIGITS and no overflow: pulse `passcode_valid`, go to IDLE, keep `passcode`, count=0.
  - any other case: pulse `entry_error`, clear `passcode` and the overflow flag, count=0, go to IDLE.
- COLLECT, `key_clear`: clear `passcode`, count, and the overflow flag; go to IDLE. No error pulse.
- Simultaneous strobes in the same cycle: priority is clear > enter > digit. The lower-priority strobes are dropped.
- Reset mid-entry aborts immediately to reset values. No pulse is emitted.

## Timing
- All outputs are registered.
- A strobe sampled on edge N produces the output change visible after edge N.
- `passcode_valid` and `entry_error` are high for exactly one cycle.
- Back-to-back digits on consecutive cycles are accepted; there is no handshake back-pressure.
- Minimum submit: 8 digit cycles + 1 enter cycle. `passcode_valid` appears 1 cycle after the enter.
- Timer: counts cycles in COLLECT with no `key_valid`. When it reaches TIMEOUT_CYCLES, take the same action as a short enter (`entry_error` pulse, clear, IDLE).
- If `key_enter` and expiry land on the same cycle, enter takes precedence.

## Configuration
- `KEYPAD_TIMEOUT_EN` defined: inactivity timer compiled in, behaving as described above.
- `KEYPAD_TIMEOUT_EN` not defined: no timer logic. COLLECT waits indefinitely. `TIMEOUT_CYCLES` is ignored.

## Test plan
- Full entry: digits 3,3,3,3,3,3,3,3 then enter -> `passcode`=16'hFFFF, `passcode_valid` high for 1 cycle, `digit_count` returns to 0.
- Ordering: digits 0,1,2,3,0,1,2,3 then enter -> `passcode`=16'h1B1B.
- Short entry: 5 digits then enter -> `entry_error` pulse, `passcode`=0, no `passcode_valid`.
- Overflow and clear:
  - 9 digits then enter -> `entry_error` pulse.
  - 4 digits, clear, then 8 digits of 2 and enter -> `passcode`=16'hAAAA with valid.
- Priority and reset:
  - Clear and enter in the same cycle with 8 digits held -> no pulse, IDLE.
  - `rst_n`=1 after 6 digits -> all outputs at 0 asynchronously.
- Timeout (`KEYPAD_TIMEOUT_EN`, TIMEOUT_CYCLES=10): 3 digits then 10 idle cycles -> `entry_error` pulse, `entry_busy`=0. Without the macro, the same stimulus leaves `digit_count`=3.
